// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
// Skid-stage state, depth and inter-stage payload bundles.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    BUSY,
    FULL
  } skid_state_t;

  localparam int SKID_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        halt;
  } id_ex_t;

  function automatic logic [1:0] skid_count(skid_state_t s);
    logic [1:0] n;
    n = 2'd0;
    unique case (s)
      BUSY:    n = 2'd1;
      FULL:    n = 2'(SKID_DEPTH);
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipeline_skid_stage.sv
// Two-entry pipeline register with registered in_ready.
// Synchronous flush and a sticky halt detector.
module pipeline_skid_stage
  import cpu_types_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int HALT_EN  = 1,
  parameter int HALT_BIT = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic             halted
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             halted_q, halted_d;
  logic             acc, pop;

  // Handshake outputs come from registered state only.
  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = main_q;
    count     = skid_count(state_q);
    halted    = halted_q;
    in_ready  = (state_q != FULL) && !halted_q;
    acc       = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Next state; flush overrides every transition but not halt.
  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    halted_d = halted_q;
    if ((HALT_EN != 0) && pop && main_q[HALT_BIT])
      halted_d = 1'b1;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            main_d  = in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (acc && pop) begin
            main_d = in_data;
          end else if (acc) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and sticky halt flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= EMPTY;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Main entry, presented downstream.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) main_q <= '0;
    else       main_q <= main_d;
  end

  // Skid entry, absorbs the item accepted under backpressure.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) skid_q <= '0;
    else       skid_q <= skid_d;
  end

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Bench for pipeline_skid_stage.
// Table vectors plus a queue model of the two-entry stage.
module tb_pipeline_skid_stage;

  logic        clk;
  logic        n_rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_halted;
  logic [31:0] a_out_data;
  logic [1:0]  a_count;
  logic        h_in_ready, h_out_valid, h_halted;
  logic [31:0] h_out_data;
  logic [1:0]  h_count;

  pipeline_skid_stage #(.WIDTH(32), .HALT_EN(1), .HALT_BIT(31)) dut (
    .CLK(clk), .nRST(n_rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data),
    .out_ready(out_ready), .count(a_count), .halted(a_halted)
  );

  pipeline_skid_stage #(.WIDTH(32), .HALT_EN(1), .HALT_BIT(0)) dut_h (
    .CLK(clk), .nRST(n_rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(h_in_ready),
    .out_valid(h_out_valid), .out_data(h_out_data),
    .out_ready(out_ready), .count(h_count), .halted(h_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] q[$];
  logic        halted_m;
  logic        zero_m;
  logic        sel;
  int          hb;

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic [1:0]  ecnt;
    logic        erdy;
  } vec_t;

  vec_t tbl [25];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    halted_m = 1'b0;
    zero_m   = 1'b1;
  endtask

  task automatic step(input logic fl, input logic iv, input logic [31:0] d,
                      input logic ordy, input logic use_tbl,
                      input logic [1:0] ecnt, input logic erdy);
    logic        ov, rdy, hl, rdy_m, acc_m, pop_m;
    logic [31:0] od;
    logic [1:0]  cn;
    logic [31:0] popped;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    ov  = sel ? h_out_valid : a_out_valid;
    od  = sel ? h_out_data  : a_out_data;
    rdy = sel ? h_in_ready  : a_in_ready;
    hl  = sel ? h_halted    : a_halted;
    cn  = sel ? h_count     : a_count;
    rdy_m = (q.size() < 2) && !halted_m;
    chk("out_valid", 32'(ov), 32'(q.size() != 0));
    chk("count", 32'(cn), 32'(q.size()));
    chk("in_ready", 32'(rdy), 32'(rdy_m));
    chk("halted", 32'(hl), 32'(halted_m));
    if (use_tbl) begin
      chk("tbl_count", 32'(cn), 32'(ecnt));
      chk("tbl_in_ready", 32'(rdy), 32'(erdy));
    end
    if (zero_m && q.size() == 0)
      chk("out_data_zero", od, 32'h0);
    acc_m = iv && rdy_m;
    pop_m = (q.size() != 0) && ordy;
    if (pop_m) begin
      popped = q.pop_front();
      chk("out_data", od, popped);
      if (popped[hb]) halted_m = 1'b1;
    end
    if (fl) begin
      q.delete();
      zero_m = 1'b1;
    end else if (acc_m) begin
      q.push_back(d);
      zero_m = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hstep(input logic fl, input logic iv, input logic [31:0] d,
                       input logic ordy);
    step(fl, iv, d, ordy, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    tbl = '{
      '{1'b0, 1'b1, 32'h1,  1'b1, 2'd0, 1'b1},
      '{1'b0, 1'b1, 32'h2,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'h3,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'h4,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'h5,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'h6,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'h7,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'h8,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1},
      '{1'b0, 1'b1, 32'hA,  1'b0, 2'd0, 1'b1},
      '{1'b0, 1'b1, 32'hB,  1'b0, 2'd1, 1'b1},
      '{1'b0, 1'b1, 32'hC,  1'b0, 2'd2, 1'b0},
      '{1'b0, 1'b1, 32'hC,  1'b0, 2'd2, 1'b0},
      '{1'b0, 1'b1, 32'hC,  1'b1, 2'd2, 1'b0},
      '{1'b0, 1'b1, 32'hC,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1},
      '{1'b0, 1'b1, 32'h11, 1'b0, 2'd0, 1'b1},
      '{1'b0, 1'b1, 32'h22, 1'b0, 2'd1, 1'b1},
      '{1'b1, 1'b1, 32'h33, 1'b0, 2'd2, 1'b0},
      '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0, 1'b1},
      '{1'b0, 1'b1, 32'h44, 1'b0, 2'd0, 1'b1},
      '{1'b1, 1'b0, 32'h0,  1'b1, 2'd1, 1'b1},
      '{1'b0, 1'b0, 32'h0,  1'b0, 2'd0, 1'b1}
    };
    sel       = 1'b0;
    hb        = 31;
    n_rst     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_out_valid", 32'(a_out_valid), 32'h0);
    chk("rst_out_data", a_out_data, 32'h0);
    chk("rst_count", 32'(a_count), 32'h0);
    chk("rst_in_ready", 32'(a_in_ready), 32'h1);
    chk("rst_halted", 32'(a_halted), 32'h0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++)
      step(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy,
           1'b1, tbl[i].ecnt, tbl[i].erdy);
    chk("sb_empty_a", 32'(q.size()), 32'h0);

    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    model_reset();
    sel = 1'b1;
    hb  = 0;
    @(posedge clk);
    #1;
    hstep(1'b0, 1'b1, 32'h4, 1'b1);
    hstep(1'b0, 1'b1, 32'h5, 1'b1);
    chk("halt_before", 32'(h_halted), 32'h0);
    hstep(1'b0, 1'b0, 32'h0, 1'b1);
    chk("halt_set", 32'(h_halted), 32'h1);
    chk("halt_in_ready", 32'(h_in_ready), 32'h0);
    for (int i = 0; i < 3; i++)
      hstep(1'b0, 1'b1, 32'h6, 1'b1);
    chk("halt_no_accept", 32'(h_out_valid), 32'h0);
    hstep(1'b1, 1'b1, 32'h6, 1'b1);
    chk("halt_after_flush", 32'(h_halted), 32'h1);
    hstep(1'b0, 1'b0, 32'h0, 1'b0);

    sel = 1'b0;
    hb  = 31;
    model_reset();
    hstep(1'b0, 1'b1, 32'h71, 1'b0);
    hstep(1'b0, 1'b1, 32'h72, 1'b0);
    chk("full_count", 32'(a_count), 32'h2);
    in_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(a_out_valid), 32'h0);
    chk("arst_out_data", a_out_data, 32'h0);
    chk("arst_count", 32'(a_count), 32'h0);
    chk("arst_in_ready", 32'(a_in_ready), 32'h1);
    chk("arst_halted_h", 32'(h_halted), 32'h0);
    model_reset();
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    hstep(1'b0, 1'b1, 32'h7, 1'b0);
    chk("lat_valid", 32'(a_out_valid), 32'h1);
    chk("lat_data", a_out_data, 32'h7);
    hstep(1'b0, 1'b0, 32'h0, 1'b1);
    hstep(1'b0, 1'b0, 32'h0, 1'b0);
    chk("sb_empty_end", 32'(q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
